castle_move_gen: RTL and testbench

- Producer side of the castling-rights interface. It takes a latched board, the side to move and `castle_mask`, and emits zero, one or two castling moves.
- Each move carries the post-move board and the updated `castle_mask`, which the downstream evaluation and search stages consume.
- Sits in the move-generation stage, in parallel with the ordinary piece move generators.
- Results go out through a valid/ready stream into the move FIFO, and a done pulse marks the end of generation.

---
 rtl/castle_move_gen.sv | 278 +++++++++++++++++++++++++++
 tb/tb_castle_move_gen.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/castle_move_gen.sv
// castle_move_gen: castling move producer for the move-generation stage.
// Latches a board on board_valid, checks short/long castling rights and
// occupancy on the mover's base rank, streams up to two post-castle boards
// over a valid/ready port, then pulses gen_done with the number emitted.
//
// Ports:
//   clk, reset (async, active low)
//   board_valid, board, castle_mask, white_to_move, attacked : job input
//   clear_gen                   : synchronous abort back to IDLE
//   move_valid / move_ready     : result handshake
//   move_board, move_castle_mask, move_short : result payload
//   gen_done, move_count        : end-of-run pulse and run total
//
// Parameters:
//   LONG_FIRST  : 1 = long castle evaluated/emitted before short
//   COUNT_WIDTH : width of move_count, must be at least 2
//
// Build option:
//   CASTLE_ATTACK_CHECK_EN : when defined, a castle whose king start,
//   transit or destination square is attacked is rejected. When undefined
//   the attacked input is ignored and the generator is pseudo-legal.

`ifndef PIECE_WIDTH
`define PIECE_WIDTH 4
`endif
`ifndef EMPTY_POSN
`define EMPTY_POSN (`PIECE_WIDTH'(0))
`endif
`ifndef WHITE_ROOK
`define WHITE_ROOK (`PIECE_WIDTH'(4))
`endif
`ifndef WHITE_KING
`define WHITE_KING (`PIECE_WIDTH'(6))
`endif
`ifndef BLACK_KNIGHT
`define BLACK_KNIGHT (`PIECE_WIDTH'(10))
`endif
`ifndef BLACK_ROOK
`define BLACK_ROOK (`PIECE_WIDTH'(12))
`endif
`ifndef BLACK_KING
`define BLACK_KING (`PIECE_WIDTH'(14))
`endif
`ifndef CASTLE_WHITE_SHORT
`define CASTLE_WHITE_SHORT 0
`endif
`ifndef CASTLE_WHITE_LONG
`define CASTLE_WHITE_LONG 1
`endif
`ifndef CASTLE_BLACK_SHORT
`define CASTLE_BLACK_SHORT 2
`endif
`ifndef CASTLE_BLACK_LONG
`define CASTLE_BLACK_LONG 3
`endif

module castle_move_gen #(
    parameter int LONG_FIRST  = 0,
    parameter int COUNT_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        board_valid,
    input  logic [64*`PIECE_WIDTH-1:0]  board,
    input  logic [3:0]                  castle_mask,
    input  logic                        white_to_move,
    input  logic                        clear_gen,
    input  logic [63:0]                 attacked,
    output logic                        move_valid,
    input  logic                        move_ready,
    output logic [64*`PIECE_WIDTH-1:0]  move_board,
    output logic [3:0]                  move_castle_mask,
    output logic                        move_short,
    output logic                        gen_done,
    output logic [COUNT_WIDTH-1:0]      move_count
);

    localparam int PW = `PIECE_WIDTH;
    localparam int BW = 64 * PW;
    localparam bit LF = (LONG_FIRST != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK_A,
        S_EMIT_A,
        S_CHECK_B,
        S_EMIT_B,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [BW-1:0]          r_board;
    logic [3:0]             r_mask;
    logic                   r_white;
    logic [BW-1:0]          r_move_board;
    logic [3:0]             r_move_mask;
    logic                   r_move_short;
    logic                   r_legal;
    logic [COUNT_WIDTH-1:0] r_count;

`ifdef CASTLE_ATTACK_CHECK_EN
    logic [63:0]            r_attacked;
`else
    logic                   w_unused_attacked;
    assign w_unused_attacked = ^attacked;
`endif

    // Bit offset of a square's piece field inside the flat board vector.
    function automatic int slot(input logic [2:0] rank, input logic [2:0] file);
        return int'({rank, file}) * PW;
    endfunction

    logic [2:0]    w_rank;
    logic [PW-1:0] w_king;
    logic [PW-1:0] w_rook;
    logic          w_right_s;
    logic          w_right_l;
    logic          w_short_ok;
    logic          w_long_ok;
    logic [3:0]    w_clear_bits;
    logic [3:0]    w_new_mask;
    logic [BW-1:0] w_short_board;
    logic [BW-1:0] w_long_board;
    logic          w_check_short;
    logic          w_check_legal;
    logic          w_in_check;
    logic          w_in_emit;

    assign w_rank = r_white ? 3'd0 : 3'd7;
    assign w_king = r_white ? `WHITE_KING : `BLACK_KING;
    assign w_rook = r_white ? `WHITE_ROOK : `BLACK_ROOK;

    assign w_right_s = r_white ? r_mask[`CASTLE_WHITE_SHORT]
                               : r_mask[`CASTLE_BLACK_SHORT];
    assign w_right_l = r_white ? r_mask[`CASTLE_WHITE_LONG]
                               : r_mask[`CASTLE_BLACK_LONG];

    always_comb begin
        w_short_ok = w_right_s
            && (r_board[slot(w_rank, 3'd4) +: PW] == w_king)
            && (r_board[slot(w_rank, 3'd7) +: PW] == w_rook)
            && (r_board[slot(w_rank, 3'd5) +: PW] == `EMPTY_POSN)
            && (r_board[slot(w_rank, 3'd6) +: PW] == `EMPTY_POSN);
        w_long_ok = w_right_l
            && (r_board[slot(w_rank, 3'd4) +: PW] == w_king)
            && (r_board[slot(w_rank, 3'd0) +: PW] == w_rook)
            && (r_board[slot(w_rank, 3'd1) +: PW] == `EMPTY_POSN)
            && (r_board[slot(w_rank, 3'd2) +: PW] == `EMPTY_POSN)
            && (r_board[slot(w_rank, 3'd3) +: PW] == `EMPTY_POSN);
`ifdef CASTLE_ATTACK_CHECK_EN
        // King may not start on, pass through, or land on an attacked square.
        if (r_attacked[{w_rank, 3'd4}] || r_attacked[{w_rank, 3'd5}]
            || r_attacked[{w_rank, 3'd6}]) begin
            w_short_ok = 1'b0;
        end
        if (r_attacked[{w_rank, 3'd4}] || r_attacked[{w_rank, 3'd3}]
            || r_attacked[{w_rank, 3'd2}]) begin
            w_long_ok = 1'b0;
        end
`endif
    end

    always_comb begin
        w_short_board = r_board;
        w_short_board[slot(w_rank, 3'd4) +: PW] = `EMPTY_POSN;
        w_short_board[slot(w_rank, 3'd7) +: PW] = `EMPTY_POSN;
        w_short_board[slot(w_rank, 3'd6) +: PW] = w_king;
        w_short_board[slot(w_rank, 3'd5) +: PW] = w_rook;
    end

    always_comb begin
        w_long_board = r_board;
        w_long_board[slot(w_rank, 3'd4) +: PW] = `EMPTY_POSN;
        w_long_board[slot(w_rank, 3'd0) +: PW] = `EMPTY_POSN;
        w_long_board[slot(w_rank, 3'd2) +: PW] = w_king;
        w_long_board[slot(w_rank, 3'd3) +: PW] = w_rook;
    end

    // Castling in either direction forfeits both of the mover's rights.
    assign w_clear_bits = r_white
        ? ((4'd1 << `CASTLE_WHITE_SHORT) | (4'd1 << `CASTLE_WHITE_LONG))
        : ((4'd1 << `CASTLE_BLACK_SHORT) | (4'd1 << `CASTLE_BLACK_LONG));
    assign w_new_mask = r_mask & ~w_clear_bits;

    // Slot A is short unless LONG_FIRST; slot B is the other one.
    assign w_check_short = (r_state == S_CHECK_A) ? !LF : LF;
    assign w_check_legal = w_check_short ? w_short_ok : w_long_ok;

    assign w_in_check = (r_state == S_CHECK_A) || (r_state == S_CHECK_B);
    assign w_in_emit  = (r_state == S_EMIT_A) || (r_state == S_EMIT_B);

    always_comb begin
        w_next = r_state;
        if (clear_gen) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (board_valid) begin
                        w_next = S_CHECK_A;
                    end
                end
                S_CHECK_A: begin
                    w_next = w_check_legal ? S_EMIT_A : S_CHECK_B;
                end
                S_EMIT_A: begin
                    if (move_ready) begin
                        w_next = S_CHECK_B;
                    end
                end
                S_CHECK_B: begin
                    w_next = w_check_legal ? S_EMIT_B : S_DONE;
                end
                S_EMIT_B: begin
                    if (move_ready) begin
                        w_next = S_DONE;
                    end
                end
                S_DONE: begin
                    w_next = S_IDLE;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_board      <= '0;
            r_mask       <= '0;
            r_white      <= 1'b0;
            r_move_board <= '0;
            r_move_mask  <= '0;
            r_move_short <= 1'b0;
            r_legal      <= 1'b0;
            r_count      <= '0;
`ifdef CASTLE_ATTACK_CHECK_EN
            r_attacked   <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (!clear_gen) begin
                if ((r_state == S_IDLE) && board_valid) begin
                    r_board <= board;
                    r_mask  <= castle_mask;
                    r_white <= white_to_move;
                    r_count <= '0;
`ifdef CASTLE_ATTACK_CHECK_EN
                    r_attacked <= attacked;
`endif
                end
                if (w_in_check) begin
                    r_legal      <= w_check_legal;
                    r_move_short <= w_check_short;
                    r_move_mask  <= w_new_mask;
                    r_move_board <= w_check_short ? w_short_board
                                                  : w_long_board;
                end
                if (w_in_emit && move_ready) begin
                    r_count <= r_count + COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign move_valid       = w_in_emit && r_legal;
    assign move_board       = r_move_board;
    assign move_castle_mask = r_move_mask;
    assign move_short       = r_move_short;
    assign gen_done         = (r_state == S_DONE);
    assign move_count       = r_count;

endmodule

// File: tb/tb_castle_move_gen.sv
// tb_castle_move_gen: randomized and directed checks of castle_move_gen
// against a square-level castling model.

`ifndef PIECE_WIDTH
`define PIECE_WIDTH 4
`endif
`ifndef EMPTY_POSN
`define EMPTY_POSN (`PIECE_WIDTH'(0))
`endif
`ifndef WHITE_ROOK
`define WHITE_ROOK (`PIECE_WIDTH'(4))
`endif
`ifndef WHITE_KING
`define WHITE_KING (`PIECE_WIDTH'(6))
`endif
`ifndef BLACK_KNIGHT
`define BLACK_KNIGHT (`PIECE_WIDTH'(10))
`endif
`ifndef BLACK_ROOK
`define BLACK_ROOK (`PIECE_WIDTH'(12))
`endif
`ifndef BLACK_KING
`define BLACK_KING (`PIECE_WIDTH'(14))
`endif

module tb_castle_move_gen;

    localparam int PW = `PIECE_WIDTH;
    localparam int BW = 64 * PW;
    localparam int LF = 0;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          board_valid;
    logic [BW-1:0] board;
    logic [3:0]    castle_mask;
    logic          white_to_move;
    logic          clear_gen;
    logic [63:0]   attacked;
    logic          move_valid;
    logic          move_ready;
    logic [BW-1:0] move_board;
    logic [3:0]    move_castle_mask;
    logic          move_short;
    logic          gen_done;
    logic [CW-1:0] move_count;

    always #5 clk = ~clk;

    castle_move_gen #(.LONG_FIRST(LF), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .board_valid(board_valid),
        .board(board), .castle_mask(castle_mask),
        .white_to_move(white_to_move), .clear_gen(clear_gen),
        .attacked(attacked), .move_valid(move_valid),
        .move_ready(move_ready), .move_board(move_board),
        .move_castle_mask(move_castle_mask), .move_short(move_short),
        .gen_done(gen_done), .move_count(move_count)
    );

    typedef struct packed {
        logic [BW-1:0] b;
        logic [3:0]    m;
        logic          s;
    } mv_t;

    logic [PW-1:0] cur_b [64];
    logic [3:0]    cur_mask;
    logic          cur_white;
    logic [63:0]   cur_att;

    mv_t exp_q [$];
    mv_t got_q [$];
    int  first_valid, done_cyc, done_cnt, stab_bad;
    int  n_tests = 0;
    int  n_fail  = 0;

    function automatic logic [BW-1:0] pack_board(input logic [PW-1:0] a [64]);
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) v[i*PW +: PW] = a[i];
        return v;
    endfunction

    function automatic logic [PW-1:0] sq_of(input logic [BW-1:0] b, input int sq);
        return b[sq*PW +: PW];
    endfunction

    // Reference: king walks two squares toward its rook, rook hops over it.
    task automatic model_moves();
        int r, rook_f, dir, right;
        bit is_long, ok;
        logic [PW-1:0] k, rk;
        logic [PW-1:0] nb [64];
        mv_t e;
        exp_q.delete();
        r  = cur_white ? 0 : 7;
        k  = cur_white ? `WHITE_KING : `BLACK_KING;
        rk = cur_white ? `WHITE_ROOK : `BLACK_ROOK;
        for (int n = 0; n < 2; n++) begin
            is_long = (n == 0) ? (LF != 0) : (LF == 0);
            rook_f  = is_long ? 0 : 7;
            dir     = is_long ? -1 : 1;
            right   = (cur_white ? 0 : 2) + (is_long ? 1 : 0);
            ok = cur_mask[right] && (cur_b[r*8+4] == k)
                 && (cur_b[r*8+rook_f] == rk);
            for (int f = 4 + dir; f != rook_f; f += dir)
                if (cur_b[r*8+f] != `EMPTY_POSN) ok = 0;
`ifdef CASTLE_ATTACK_CHECK_EN
            for (int s = 0; s < 3; s++)
                if (cur_att[r*8+4+dir*s]) ok = 0;
`endif
            if (ok) begin
                nb = cur_b;
                nb[r*8+4]       = `EMPTY_POSN;
                nb[r*8+rook_f]  = `EMPTY_POSN;
                nb[r*8+4+2*dir] = k;
                nb[r*8+4+dir]   = rk;
                e.b = pack_board(nb);
                e.m = cur_mask;
                e.m[cur_white ? 0 : 2] = 1'b0;
                e.m[cur_white ? 1 : 3] = 1'b0;
                e.s = !is_long;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) cur_b[i] = `EMPTY_POSN;
        cur_att = '0;
    endtask

    // mode 0: ready always high, 1: random ready, 2: low for 5 valid cycles.
    task automatic run_board(input int mode, input bit rand_bv);
        int cyc, stall;
        bit rd, have_hold;
        mv_t held, cur;
        got_q.delete();
        first_valid = -1; done_cyc = -1; done_cnt = -1; stab_bad = 0;
        stall = 0; have_hold = 0; held = '0;
        board         = pack_board(cur_b);
        castle_mask   = cur_mask;
        white_to_move = cur_white;
        attacked      = cur_att;
        board_valid   = 1'b1;
        move_ready    = 1'b0;
        @(posedge clk); #1;
        board_valid = 1'b0;
        cyc = 1;
        while (cyc <= 60) begin
            if (gen_done) begin
                done_cyc = cyc;
                done_cnt = int'(move_count);
                break;
            end
            cur.b = move_board; cur.m = move_castle_mask; cur.s = move_short;
            if (have_hold && (!move_valid || cur !== held)) stab_bad++;
            if (move_valid && first_valid < 0) first_valid = cyc;
            case (mode)
                0: rd = 1'b1;
                1: rd = 1'($urandom_range(0, 1));
                default: begin
                    rd = (stall >= 5);
                    if (move_valid) stall++;
                end
            endcase
            move_ready = rd;
            if (move_valid && rd) begin
                got_q.push_back(cur);
                have_hold = 0;
            end else if (move_valid) begin
                held = cur;
                have_hold = 1;
            end else begin
                have_hold = 0;
            end
            board_valid = rand_bv ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        board_valid = 1'b0;
        move_ready  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic cmp_moves(input string tag);
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_nmoves got %0d want %0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_move%0d got m=%h s=%b b=%h want m=%h s=%b b=%h",
                         tag, i, got_q[i].m, got_q[i].s, got_q[i].b,
                         exp_q[i].m, exp_q[i].s, exp_q[i].b);
            end
        end
        n_tests++;
        if (done_cnt !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count got %0d want %0d", tag, done_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; board_valid = 1'b0; clear_gen = 1'b0;
        move_ready = 1'b0; board = '0; castle_mask = '0;
        white_to_move = 1'b0; attacked = '0;
        #12;
        n_tests++;
        if ({move_valid, gen_done, move_short} !== 3'b000
            || move_count !== '0 || move_castle_mask !== 4'h0
            || move_board !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b d=%b s=%b c=%0d m=%h want all zero",
                     move_valid, gen_done, move_short, move_count, move_castle_mask);
        end
        #5 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_white_both();
        mv_t g;
        clear_board();
        cur_b[4] = `WHITE_KING; cur_b[0] = `WHITE_ROOK; cur_b[7] = `WHITE_ROOK;
        cur_mask = 4'b1111; cur_white = 1'b1;
        model_moves();
        run_board(0, 0);
        cmp_moves("white_both");
        g = (got_q.size() > 0) ? got_q[0] : '0;
        n_tests++;
        if (g.s !== 1'b1 || sq_of(g.b, 6) !== `WHITE_KING || sq_of(g.b, 5) !== `WHITE_ROOK
            || sq_of(g.b, 4) !== `EMPTY_POSN || sq_of(g.b, 7) !== `EMPTY_POSN
            || g.m !== 4'b1100) begin
            n_fail++;
            $display("FAIL white_short_hand got s=%b g1=%h f1=%h e1=%h h1=%h m=%h want 1 K R 0 0 c",
                     g.s, sq_of(g.b, 6), sq_of(g.b, 5), sq_of(g.b, 4), sq_of(g.b, 7), g.m);
        end
        g = (got_q.size() > 1) ? got_q[1] : '0;
        n_tests++;
        if (g.s !== 1'b0 || sq_of(g.b, 2) !== `WHITE_KING || sq_of(g.b, 3) !== `WHITE_ROOK
            || g.m !== 4'b1100) begin
            n_fail++;
            $display("FAIL white_long_hand got s=%b c1=%h d1=%h m=%h want 0 K R c",
                     g.s, sq_of(g.b, 2), sq_of(g.b, 3), g.m);
        end
        n_tests++;
        if (first_valid !== 2) begin
            n_fail++;
            $display("FAIL first_valid_latency got %0d want 2", first_valid);
        end
        n_tests++;
        if (done_cyc < 0 || done_cyc > 6) begin
            n_fail++;
            $display("FAIL b2b_done_latency got %0d want within 6", done_cyc);
        end
    endtask

    task automatic test_black_knight();
        mv_t g;
        clear_board();
        cur_b[60] = `BLACK_KING; cur_b[56] = `BLACK_ROOK; cur_b[63] = `BLACK_ROOK;
        cur_b[57] = `BLACK_KNIGHT;
        cur_mask = 4'b1111; cur_white = 1'b0;
        model_moves();
        run_board(0, 0);
        cmp_moves("black_knight");
        g = (got_q.size() > 0) ? got_q[0] : '0;
        n_tests++;
        if (got_q.size() !== 1 || g.s !== 1'b1 || sq_of(g.b, 62) !== `BLACK_KING
            || sq_of(g.b, 61) !== `BLACK_ROOK || g.m !== 4'b0011 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL black_short_hand got n=%0d s=%b g8=%h f8=%h m=%h c=%0d want 1 1 K R 3 1",
                     got_q.size(), g.s, sq_of(g.b, 62), sq_of(g.b, 61), g.m, done_cnt);
        end
    endtask

    task automatic test_no_rights();
        clear_board();
        cur_b[4] = `WHITE_KING; cur_b[0] = `WHITE_ROOK; cur_b[7] = `WHITE_ROOK;
        cur_mask = 4'b0000; cur_white = 1'b1;
        run_board(0, 0);
        n_tests++;
        if (first_valid !== -1 || done_cyc !== 3 || done_cnt !== 0) begin
            n_fail++;
            $display("FAIL no_rights got valid_at=%0d done_at=%0d cnt=%0d want -1 3 0",
                     first_valid, done_cyc, done_cnt);
        end
    endtask

    task automatic test_ready_stall();
        clear_board();
        cur_b[4] = `WHITE_KING; cur_b[0] = `WHITE_ROOK; cur_b[7] = `WHITE_ROOK;
        cur_mask = 4'b1111; cur_white = 1'b1;
        model_moves();
        run_board(2, 0);
        cmp_moves("stall");
        n_tests++;
        if (stab_bad !== 0) begin
            n_fail++;
            $display("FAIL stall_stable got %0d unstable cycles want 0", stab_bad);
        end
    endtask

    task automatic test_clear();
        int seen;
        clear_board();
        cur_b[4] = `WHITE_KING; cur_b[0] = `WHITE_ROOK; cur_b[7] = `WHITE_ROOK;
        cur_mask = 4'b1111; cur_white = 1'b1;
        board = pack_board(cur_b); castle_mask = cur_mask;
        white_to_move = cur_white; attacked = cur_att;
        move_ready = 1'b0; board_valid = 1'b1;
        @(posedge clk); #1; board_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (move_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_pre_valid got %b want 1", move_valid);
        end
        clear_gen = 1'b1;
        @(posedge clk); #1; clear_gen = 1'b0;
        n_tests++;
        if (move_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_valid_drop got %b want 0", move_valid);
        end
        seen = 0;
        repeat (8) begin
            move_ready = 1'($urandom_range(0, 1));
            if (move_valid || gen_done) seen++;
            @(posedge clk); #1;
        end
        move_ready = 1'b0;
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL clear_idle got %0d active cycles want 0", seen);
        end
        board_valid = 1'b1; clear_gen = 1'b1;
        @(posedge clk); #1;
        board_valid = 1'b0; clear_gen = 1'b0;
        seen = 0;
        repeat (6) begin
            if (move_valid || gen_done) seen++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL clear_over_start got %0d active cycles want 0", seen);
        end
        model_moves();
        run_board(0, 0);
        cmp_moves("after_clear");
    endtask

    task automatic test_reset_midrun();
        clear_board();
        cur_b[4] = `WHITE_KING; cur_b[7] = `WHITE_ROOK;
        cur_mask = 4'b0001; cur_white = 1'b1;
        board = pack_board(cur_b); castle_mask = cur_mask;
        white_to_move = 1'b1; attacked = '0;
        move_ready = 1'b0; board_valid = 1'b1;
        @(posedge clk); #1; board_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (move_valid !== 1'b0 || gen_done !== 1'b0 || move_count !== '0
            || move_board !== '0 || move_castle_mask !== 4'h0 || move_short !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset got v=%b d=%b c=%0d m=%h s=%b want zeros",
                     move_valid, gen_done, move_count, move_castle_mask, move_short);
        end
        @(posedge clk); #4;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_attack();
        clear_board();
        cur_b[4] = `WHITE_KING; cur_b[0] = `WHITE_ROOK; cur_b[7] = `WHITE_ROOK;
        cur_mask = 4'b1111; cur_white = 1'b1;
        cur_att = 64'h20;
        model_moves();
        run_board(0, 0);
        cmp_moves("attack_f1");
        n_tests++;
`ifdef CASTLE_ATTACK_CHECK_EN
        if (done_cnt !== 1 || got_q.size() !== 1 || got_q[0].s !== 1'b0) begin
            n_fail++;
            $display("FAIL attack_hand got cnt=%0d n=%0d want 1 long only", done_cnt, got_q.size());
        end
`else
        if (done_cnt !== 2) begin
            n_fail++;
            $display("FAIL attack_hand got cnt=%0d want 2", done_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic [PW-1:0] own_k, own_r, opp_k;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < 64; i++) cur_b[i] = PW'($urandom_range(0, 15));
            for (int rr = 0; rr < 8; rr += 7) begin
                own_k = (rr == 0) ? `WHITE_KING : `BLACK_KING;
                opp_k = (rr == 0) ? `BLACK_KING : `WHITE_KING;
                own_r = (rr == 0) ? `WHITE_ROOK : `BLACK_ROOK;
                if ($urandom_range(0, 3) != 0)
                    cur_b[rr*8+4] = ($urandom_range(0, 4) == 0) ? opp_k : own_k;
                if ($urandom_range(0, 3) != 0) cur_b[rr*8+0] = own_r;
                if ($urandom_range(0, 3) != 0) cur_b[rr*8+7] = own_r;
                for (int f = 1; f < 7; f++)
                    if (f != 4 && $urandom_range(0, 5) != 0) cur_b[rr*8+f] = `EMPTY_POSN;
            end
            cur_mask  = 4'($urandom);
            cur_white = 1'($urandom);
            cur_att   = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            model_moves();
            run_board(1, 1);
            cmp_moves("random");
            n_tests++;
            if (stab_bad !== 0 || done_cyc < 0) begin
                n_fail++;
                $display("FAIL random_proto it=%0d got unstable=%0d done_at=%0d want 0 and >=0",
                         it, stab_bad, done_cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_white_both();
        test_black_knight();
        test_no_rights();
        test_ready_stall();
        test_clear();
        test_reset_midrun();
        test_attack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
